// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared constants and types for the FIFO pointer/flag controller.
//   FIFO_DATA_W / FIFO_ADDR_W / FIFO_DEPTH : geometry of the backing memory
//   FIFO_AF_THRESH / FIFO_AE_THRESH        : default almost-full/empty thresholds
//   fifo_status_t                          : registered status flag bundle
package fifo_ctrl_pkg;

  localparam int FIFO_DATA_W    = 10;
  localparam int FIFO_ADDR_W    = 3;
  localparam int FIFO_DEPTH     = 2 ** FIFO_ADDR_W;
  localparam int FIFO_AF_THRESH = 6;
  localparam int FIFO_AE_THRESH = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow_err;
    logic underflow_err;
  } fifo_status_t;

  // Status immediately after reset: empty and almost-empty, nothing else.
  localparam fifo_status_t FIFO_STATUS_RST = '{
    full:          1'b0,
    empty:         1'b1,
    almost_full:   1'b0,
    almost_empty:  1'b1,
    overflow_err:  1'b0,
    underflow_err: 1'b0
  };

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// ptr_counter
// Wrapping W-bit address counter with enable and synchronous reset.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears the pointer to 0
//   en_i  : advance the pointer by one on this edge
//   ptr_o : current pointer value (registered)
module ptr_counter
  import fifo_ctrl_pkg::*;
#(
  parameter int W = FIFO_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Natural W-bit rollover gives the wrap from depth-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Pointer, occupancy and flag controller that turns a dual-pointer memory
// into a synchronous FIFO.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   push, pop, data_in          : producer/consumer requests and write data
//   wr_enb, rd_enb              : memory write/read enables (accepted requests)
//   wr_ptr, rd_ptr              : memory write/read addresses
//   mem_data_in                 : memory write data (data_in passed through)
//   data_valid                  : memory read data valid (pop accepted last edge)
//   full, empty                 : occupancy == depth / == 0
//   almost_full, almost_empty   : occupancy >= AF_THRESH / <= AE_THRESH
//   fifo_count                  : current occupancy, 0..depth
//   overflow_err, underflow_err : sticky error flags, cleared only by rst
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = FIFO_AF_THRESH,
  parameter int AE_THRESH = FIFO_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_enb,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_W);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Request handshake: push/pop are requests held by producer/consumer;
  // a request is taken on the rising edge where its *_acc term is high
  // (visible as wr_enb/rd_enb). A pop is taken whenever the FIFO holds data.
  // A push is taken when there is room, or when full but a pop is taken on
  // the same edge. There is no fall-through: a push into an empty FIFO never
  // satisfies a pop on the same edge. Nothing is taken while rst is high.
  logic           push_acc;
  logic           pop_acc;
  logic [CW-1:0]  count_q, count_d;
  fifo_status_t   status_q, status_d;
  logic           data_valid_q;

  always_comb begin
    pop_acc  = ~rst & pop  & ~status_q.empty;
    push_acc = ~rst & push & (~status_q.full | pop_acc);

    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are computed from the next count so they line up with fifo_count.
    status_d               = status_q;
    status_d.full          = (count_d == DEPTH_C);
    status_d.empty         = (count_d == '0);
    status_d.almost_full   = (count_d >= AF_C);
    status_d.almost_empty  = (count_d <= AE_C);
    // A push while full is only an error if no pop frees a slot this edge.
    status_d.overflow_err  = status_q.overflow_err  | (push & status_q.full & ~pop);
    status_d.underflow_err = status_q.underflow_err | (pop & status_q.empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      status_q     <= FIFO_STATUS_RST;
      data_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      status_q     <= status_d;
      data_valid_q <= pop_acc;
    end
  end

  ptr_counter #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (push_acc),
    .ptr_o (wr_ptr)
  );

  ptr_counter #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pop_acc),
    .ptr_o (rd_ptr)
  );

  assign wr_enb        = push_acc;
  assign rd_enb        = pop_acc;
  assign mem_data_in   = data_in;
  assign data_valid    = data_valid_q;
  assign fifo_count    = count_q;
  assign full          = status_q.full;
  assign empty         = status_q.empty;
  assign almost_full   = status_q.almost_full;
  assign almost_empty  = status_q.almost_empty;
  assign overflow_err  = status_q.overflow_err;
  assign underflow_err = status_q.underflow_err;

endmodule
